// File: rtl/vgc_timing_if.sv
// Raster timing bundle from vgc_timing to the VGC fetch stage and video output path.
interface vgc_timing_if;
  logic       ce_pix;
  logic [9:0] H;
  logic [8:0] V;
  logic       hsync_n;
  logic       vsync_n;
  logic       hblank;
  logic       vblank;
  logic       de;
  logic       line_start;
  logic       frame_start;
  logic       vbl_start;

  // Timing generator drives every signal.
  modport master (
    output ce_pix, H, V, hsync_n, vsync_n, hblank, vblank, de,
           line_start, frame_start, vbl_start
  );

  // Consumers only observe.
  modport slave (
    input ce_pix, H, V, hsync_n, vsync_n, hblank, vblank, de,
          line_start, frame_start, vbl_start
  );
endinterface

// File: rtl/vgc_timing.sv
// Raster timing generator: pixel clock enable, H/V position, sync, blank,
// data-enable and line/frame/vblank event strobes. Every output is
// registered on the same edge as H/V, so it always describes the H/V value
// shown alongside it. The raster is free-running; there is no handshake.
module vgc_timing #(
  parameter int CE_DIV       = 4,
  parameter int H_TOTAL      = 928,
  parameter int H_ACT_START  = 32,
  parameter int H_ACT_END    = 672,
  parameter int H_SYNC_START = 720,
  parameter int H_SYNC_END   = 788,
  parameter int V_TOTAL      = 262,
  parameter int V_ACT_START  = 16,
  parameter int V_ACT_END    = 208,
  parameter int V_SYNC_START = 230,
  parameter int V_SYNC_END   = 233
) (
  input  logic        clk_vid,
  input  logic        reset,
  vgc_timing_if.master vo
);

  localparam logic [3:0] DIV_LAST = 4'(CE_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_AS     = 10'(H_ACT_START);
  localparam logic [9:0] H_AE     = 10'(H_ACT_END);
  localparam logic [9:0] H_SS     = 10'(H_SYNC_START);
  localparam logic [9:0] H_SE     = 10'(H_SYNC_END);
  localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_AS     = 9'(V_ACT_START);
  localparam logic [8:0] V_AE     = 9'(V_ACT_END);
  localparam logic [8:0] V_SS     = 9'(V_SYNC_START);
  localparam logic [8:0] V_SE     = 9'(V_SYNC_END);

  logic [3:0] div;
  logic       tick;
  logic       h_wrap;
  logic       v_wrap;
  logic [9:0] h_next;
  logic [8:0] v_next;
  logic       hblank_next;
  logic       vblank_next;

  // The divider terminal count is the pixel edge: ce_pix rises and H/V step together.
  assign tick = (div == DIV_LAST);

  // Divider counts 0..CE_DIV-1 and wraps.
  always_ff @(posedge clk_vid) begin
    if (reset) div <= 4'd0;
    else       div <= tick ? 4'd0 : div + 4'd1;
  end

  // Next raster position and the decodes of it, so registered outputs align with H/V.
  always_comb begin
    h_wrap      = (vo.H == H_LAST);
    v_wrap      = (vo.V == V_LAST);
    h_next      = h_wrap ? 10'd0 : vo.H + 10'd1;
    v_next      = vo.V;
    if (h_wrap) v_next = v_wrap ? 9'd0 : vo.V + 9'd1;
    hblank_next = !((h_next >= H_AS) && (h_next < H_AE));
    vblank_next = !((v_next >= V_AS) && (v_next < V_AE));
  end

  // Position, decodes and strobes update on pixel edges and hold otherwise.
  always_ff @(posedge clk_vid) begin
    if (reset) begin
      vo.ce_pix      <= 1'b0;
      vo.H           <= 10'd0;
      vo.V           <= 9'd0;
      vo.hsync_n     <= 1'b1;
      vo.vsync_n     <= 1'b1;
      vo.hblank      <= 1'b1;
      vo.vblank      <= 1'b1;
      vo.de          <= 1'b0;
      vo.line_start  <= 1'b0;
      vo.frame_start <= 1'b0;
      vo.vbl_start   <= 1'b0;
    end else begin
      vo.ce_pix      <= tick;
      vo.line_start  <= 1'b0;
      vo.frame_start <= 1'b0;
      vo.vbl_start   <= 1'b0;
      if (tick) begin
        vo.H           <= h_next;
        vo.V           <= v_next;
        vo.hsync_n     <= !((h_next >= H_SS) && (h_next < H_SE));
        vo.vsync_n     <= !((v_next >= V_SS) && (v_next < V_SE));
        vo.hblank      <= hblank_next;
        vo.vblank      <= vblank_next;
        vo.de          <= !hblank_next && !vblank_next;
        vo.line_start  <= h_wrap;
        vo.frame_start <= h_wrap && v_wrap;
        vo.vbl_start   <= h_wrap && (v_next == V_AE);
      end
    end
  end

endmodule

// File: tb/tb_vgc_timing.sv
// Bench for vgc_timing: two instances (default timing, and CE_DIV=1 with a
// short frame so frame wrap, vsync and vblank edges are reached quickly)
// compared every cycle against an arithmetic raster model.
module tb_vgc_timing;

  typedef struct {
    int ce_div;
    int h_total, h_as, h_ae, h_ss, h_se;
    int v_total, v_as, v_ae, v_ss, v_se;
  } cfg_t;

  localparam int W = 28;

  logic clk_vid = 1'b0;
  logic reset   = 1'b1;
  int   cyc     = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];

  cfg_t cfg_a = '{4, 928, 32, 672, 720, 788, 262, 16, 208, 230, 233};
  cfg_t cfg_b = '{1, 928, 32, 672, 720, 788, 24, 3, 18, 20, 22};

  // Clock and reset
  always #5 clk_vid = ~clk_vid;

  vgc_timing_if vif_a ();
  vgc_timing_if vif_b ();

  vgc_timing dut_a (
    .clk_vid (clk_vid),
    .reset   (reset),
    .vo      (vif_a)
  );

  vgc_timing #(
    .CE_DIV(1), .V_TOTAL(24), .V_ACT_START(3), .V_ACT_END(18),
    .V_SYNC_START(20), .V_SYNC_END(22)
  ) dut_b (
    .clk_vid (clk_vid),
    .reset   (reset),
    .vo      (vif_b)
  );

  logic [W-1:0] got_a, got_b;
  assign got_a = {vif_a.ce_pix, vif_a.H, vif_a.V, vif_a.hsync_n, vif_a.vsync_n,
                  vif_a.hblank, vif_a.vblank, vif_a.de, vif_a.line_start,
                  vif_a.frame_start, vif_a.vbl_start};
  assign got_b = {vif_b.ce_pix, vif_b.H, vif_b.V, vif_b.hsync_n, vif_b.vsync_n,
                  vif_b.hblank, vif_b.vblank, vif_b.de, vif_b.line_start,
                  vif_b.frame_start, vif_b.vbl_start};

  // Expected outputs after edge number n since reset release (0 = in reset).
  function automatic logic [W-1:0] model(input cfg_t c, input int n);
    int p, h, v;
    logic ce, hs, vs, hb, vb, de, ls, fs, vbs;
    if (n == 0) return {1'b0, 10'd0, 9'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    p   = n / c.ce_div;
    ce  = (n % c.ce_div) == 0;
    h   = p % c.h_total;
    v   = (p / c.h_total) % c.v_total;
    hs  = !(h >= c.h_ss && h < c.h_se);
    vs  = !(v >= c.v_ss && v < c.v_se);
    hb  = !(h >= c.h_as && h < c.h_ae);
    vb  = !(v >= c.v_as && v < c.v_ae);
    de  = !hb && !vb;
    ls  = ce && (h == 0);
    fs  = ls && (v == 0);
    vbs = ls && (v == c.v_ae);
    return {ce, 10'(h), 9'(v), hs, vs, hb, vb, de, ls, fs, vbs};
  endfunction

  // Comparison: counts every call, reports mismatches.
  task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got ce=%0b H=%0d V=%0d hs=%0b vs=%0b hb=%0b vb=%0b de=%0b ls=%0b fs=%0b vbs=%0b exp ce=%0b H=%0d V=%0d hs=%0b vs=%0b hb=%0b vb=%0b de=%0b ls=%0b fs=%0b vbs=%0b",
               tag, got[27], got[26:17], got[16:8], got[7], got[6], got[5], got[4], got[3], got[2], got[1], got[0],
               exp[27], exp[26:17], exp[16:8], exp[7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Scoreboard pop after the edge has been sampled.
  task automatic pop_check(input string tag, input logic [W-1:0] got, inout logic [W-1:0] q[$]);
    logic [W-1:0] e;
    if (q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s got=%h required an expected entry, queue empty", tag, got);
    end else begin
      e = q.pop_front();
      check_val(tag, got, e);
    end
  endtask

  // Driver: n cycles with the given reset level, expectations pushed as driven.
  task automatic run_cycles(input logic rst, input int n);
    for (int i = 0; i < n; i++) begin
      reset = rst;
      cyc   = rst ? 0 : cyc + 1;
      exp_qa.push_back(model(cfg_a, cyc));
      exp_qb.push_back(model(cfg_b, cyc));
      @(posedge clk_vid);
      @(negedge clk_vid);
      pop_check($sformatf("a@%0d", cyc), got_a, exp_qa);
      pop_check($sformatf("b@%0d", cyc), got_b, exp_qb);
    end
  endtask

  initial begin
    run_cycles(1'b1, 5);
    run_cycles(1'b0, 7501 + $urandom_range(0, 2));
    run_cycles(1'b1, 1);
    run_cycles(1'b0, 3000 + $urandom_range(0, 3));
    run_cycles(1'b1, 2);
    run_cycles(1'b0, 45000);
    if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL leftover got=%0d required=0", exp_qa.size() + exp_qb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vgc_timing.md
Name: vgc_timing

Overview:
- Raster timing generator that sits directly upstream of the VGC pixel/fetch stage.
- Divides clk_vid into the pixel clock enable ce_pix.
- Produces the H/V raster position the VGC uses to schedule SCB, palette and pixel fetches. H=0..31 is the left border, 32..671 is active; SCB/palette fetch happens at H=0x38C..0x390 of the preceding line.
- Also produces sync, blank, data-enable and frame/line event strobes for the video output path.

Parameters:
- CE_DIV, 4: clk_vid cycles per pixel; legal 1..16.
- H_TOTAL, 928: pixels per line; must exceed 0x390 (912).
- H_ACT_START, 32: first active pixel.
- H_ACT_END, 672: first non-active pixel after the active region.
- H_SYNC_START, 720: first hsync pixel.
- H_SYNC_END, 788: first pixel after hsync.
- V_TOTAL, 262: lines per frame.
- V_ACT_START, 16: first active line.
- V_ACT_END, 208: first non-active line after the active region.
- V_SYNC_START, 230: first vsync line.
- V_SYNC_END, 233: first line after vsync.

Ports:
- clk_vid  in  1  video clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- ce_pix  out  1  pixel clock enable, one clk_vid cycle wide.
- H  out  10  horizontal pixel counter.
- V  out  9  vertical line counter.
- hsync_n  out  1  horizontal sync, active low.
- vsync_n  out  1  vertical sync, active low.
- hblank  out  1  high outside [H_ACT_START, H_ACT_END).
- vblank  out  1  high outside [V_ACT_START, V_ACT_END).
- de  out  1  equals ~hblank & ~vblank.
- line_start  out  1  strobe when H wraps to 0.
- frame_start  out  1  strobe when H and V both wrap to 0.
- vbl_start  out  1  strobe when V becomes V_ACT_END while H becomes 0.

Behaviour:
- Single clock domain, clk_vid. Reset is synchronous and active-high, and takes priority over everything.
- Reset values:
  - Divider counter = 0, ce_pix = 0, H = 0, V = 0.
  - hsync_n = 1, vsync_n = 1, hblank = 1, vblank = 1, de = 0.
  - line_start = 0, frame_start = 0, vbl_start = 0.
- Reset mid-line or mid-frame behaves identically: the next cycle shows the reset values, with no strobes emitted.
- Divider:
  - 4-bit counter div runs 0..CE_DIV-1 and wraps.
  - ce_pix is registered, high in the cycle after div==CE_DIV-1. Period is exactly CE_DIV cycles; the first ce_pix occurs CE_DIV cycles after reset release.
  - CE_DIV=1: ce_pix is held high from the first post-reset cycle.
- Counters advance only in cycles where ce_pix is asserted (registered pipeline, same edge as ce_pix). Within the stage that means the divider's terminal count.
  - H_next = (H==H_TOTAL-1) ? 0 : H+1.
  - V_next = V+1 only when H wraps; V wraps from V_TOTAL-1 to 0.
- All decoded outputs are computed from H_next/V_next and registered together with H/V, so every output is cycle-aligned with the H/V value it describes. Zero latency relative to H/V.
- hsync_n = 0 iff H_SYNC_START <= H < H_SYNC_END. vsync_n = 0 iff V_SYNC_START <= V < V_SYNC_END. Both change only on pixel edges.
- Strobes line_start, frame_start and vbl_start:
  - Each is high for exactly one clk_vid cycle, coincident with ce_pix, on the pixel edge where the new H/V satisfy the condition; low otherwise.
  - frame_start implies line_start in the same cycle.
- Outputs hold their value between ce_pix cycles.
- Arithmetic: compare against H_TOTAL-1 and V_TOTAL-1 exactly. No counter may exceed its total-1, even transiently.

Test Plan:
1. Reset held 5 cycles, then released, CE_DIV=4 -> ce_pix first high at cycle 4 after release, then every 4 cycles. H steps 0→1→2. hblank=1, vblank=1, de=0 throughout.
2. Run one line -> H goes 927→0 after 928 ce_pix pulses (3712 clk_vid). line_start is high exactly that one cycle. V goes 0→1. hsync_n is low for H=720..787 (68 pixels).
3. Run to V=16, H=32 -> de rises in the same cycle H becomes 32. de falls when H becomes 672. On V=207→208 at H=0, vbl_start pulses, vblank=1, de stays 0.
4. Full frame -> V=261,H=927 is followed by V=0,H=0 with frame_start and line_start both high for one cycle; next frame_start comes 243136 ce_pix later. vsync_n is low for lines 230..232.
5. Assert reset at V=100, H=500, mid-divider -> next cycle H=0, V=0, ce_pix=0, no strobes, hsync_n=1, vsync_n=1. Counting resumes as in test 1.
6. CE_DIV=1 -> ce_pix constantly 1 after reset; H increments every cycle; line length is 928 cycles.
